// File: rtl/lmg_pkg.sv
// Shared types and constants for the legal-move-generator output packer.
package lmg_pkg;

    localparam int unsigned MOVE_W     = 18;
    localparam int unsigned SLOTS      = 8;
    localparam int unsigned SLOT_PITCH = MOVE_W + 1;
    localparam int unsigned WORD_W     = SLOTS * SLOT_PITCH;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned CNT_W      = 8;

    // Every slot invalid (flag at the top of each 19-bit slot), all data zero.
    localparam logic [WORD_W-1:0] TERMINATOR_WORD = {SLOTS{1'b1, {MOVE_W{1'b0}}}};

    typedef enum logic [2:0] {
        StIdle,
        StPack,
        StFlush,
        StTerm,
        StDone
    } lmg_state_e;

endpackage

// File: rtl/move_word_fifo.sv
// Generic show-ahead synchronous FIFO; head is valid whenever empty is low.
module move_word_fifo #(
    parameter int unsigned WIDTH = 152,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmg_move_packer.sv
// Packs generated moves eight per word into a show-ahead FIFO and closes each
// list with an all-invalid terminator word.
module lmg_move_packer
    import lmg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              gen_start,
    input  logic              move_valid,
    input  logic [MOVE_W-1:0] move_data,
    input  logic              move_last,
    input  logic              gen_end,
    output logic              move_ready,
    input  logic              rden,
    output logic [WORD_W-1:0] fifoOut,
    output logic              fifoEmpty,
    output logic              done,
    output logic [CNT_W-1:0]  move_count
);

    localparam int unsigned SLOT_IDX_W = $clog2(SLOTS);

    lmg_state_e            state;
    logic [SLOT_IDX_W-1:0] slot_idx;
    logic [WORD_W-1:0]     word_q;
    logic [WORD_W-1:0]     word_d;
    logic                  word_pending;
    logic [WORD_W-1:0]     push_data;
    logic [WORD_W-1:0]     fifo_head;
    logic                  push_req;
    logic                  push_ok;
    logic                  can_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  list_end;
    logic                  word_full_now;

    assign can_push      = !fifo_full || (rden && !fifo_empty);
    assign move_ready    = (state == StPack) && !gen_start && !(word_pending && !can_push);
    assign accept        = move_valid && move_ready;
    // A move arriving with gen_end counts as the last move; a stalled move defers gen_end.
    assign list_end      = accept ? (move_last || gen_end) : (gen_end && !move_valid);
    assign word_full_now = accept && (slot_idx == SLOT_IDX_W'(SLOTS - 1));
    assign push_ok       = push_req && can_push && !gen_start;

    always_comb begin
        push_req  = 1'b0;
        push_data = word_q;
        case (state)
            StPack:  push_req = word_pending;
            StFlush: push_req = 1'b1;
            StTerm: begin
                // A full word left over from the final move goes out ahead of the terminator.
                push_req  = 1'b1;
                push_data = word_pending ? word_q : TERMINATOR_WORD;
            end
            default: push_req = 1'b0;
        endcase
    end

    always_comb begin
        word_d = (word_pending && push_ok) ? TERMINATOR_WORD : word_q;
        if (accept) begin
            word_d[int'(slot_idx) * SLOT_PITCH +: SLOT_PITCH] = {1'b0, move_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            slot_idx     <= '0;
            word_q       <= TERMINATOR_WORD;
            word_pending <= 1'b0;
            move_count   <= '0;
            done         <= 1'b0;
        end else if (gen_start) begin
            state        <= StPack;
            slot_idx     <= '0;
            word_q       <= TERMINATOR_WORD;
            word_pending <= 1'b0;
            move_count   <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                StPack: begin
                    word_q <= word_d;
                    if (word_pending && push_ok) begin
                        word_pending <= 1'b0;
                    end
                    if (accept) begin
                        slot_idx <= slot_idx + 1'b1;
                        if (move_count != '1) begin
                            move_count <= move_count + 1'b1;
                        end
                        if (word_full_now) begin
                            word_pending <= 1'b1;
                        end
                    end
                    if (list_end) begin
                        if (accept ? word_full_now : (slot_idx == '0)) begin
                            state <= StTerm;
                        end else begin
                            state <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (push_ok) begin
                        state    <= StTerm;
                        word_q   <= TERMINATOR_WORD;
                        slot_idx <= '0;
                    end
                end
                StTerm: begin
                    if (push_ok) begin
                        if (word_pending) begin
                            word_pending <= 1'b0;
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    move_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (gen_start),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (rden),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fifoOut   = fifo_empty ? TERMINATOR_WORD : fifo_head;
    assign fifoEmpty = fifo_empty;

endmodule

// File: tb/tb_lmg_move_packer.sv
// Directed bench for lmg_move_packer: list packing, flush/terminator framing,
// FIFO back-pressure, restart and reset behaviour.
module tb_lmg_move_packer;

    logic         clk;
    logic         reset;
    logic         gen_start;
    logic         move_valid;
    logic [17:0]  move_data;
    logic         move_last;
    logic         gen_end;
    logic         move_ready;
    logic         rden;
    logic [151:0] fifoOut;
    logic         fifoEmpty;
    logic         done;
    logic [7:0]   move_count;

    int           checks;
    int           failures;
    logic [151:0] term_w;
    logic [151:0] exp_w;

    lmg_move_packer dut (
        .clk        (clk),
        .reset      (reset),
        .gen_start  (gen_start),
        .move_valid (move_valid),
        .move_data  (move_data),
        .move_last  (move_last),
        .gen_end    (gen_end),
        .move_ready (move_ready),
        .rden       (rden),
        .fifoOut    (fifoOut),
        .fifoEmpty  (fifoEmpty),
        .done       (done),
        .move_count (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_gen_start();
        gen_start = 1'b1;
        tick();
        gen_start = 1'b0;
        #1;
    endtask

    task automatic send(input logic [17:0] d, input logic last, input logic end_flag);
        int n;
        move_valid = 1'b1;
        move_data  = d;
        move_last  = last;
        gen_end    = end_flag;
        #1;
        n = 0;
        while (!move_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("send_timeout", 152'(move_ready), 152'(1));
        tick();
        move_valid = 1'b0;
        move_last  = 1'b0;
        gen_end    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 152'(done), 152'(1));
    endtask

    task automatic pop_check(input string tag, input logic [151:0] exp);
        chk(tag, fifoOut, exp);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        #1;
    endtask

    // Expected word holding n consecutive moves base, base+1, ... in slots 0..n-1.
    function automatic logic [151:0] pack(input int base, input int n);
        logic [151:0] w;
        w = term_w;
        for (int i = 0; i < n; i++) begin
            w[i*19 +: 19] = {1'b0, 18'(base + i)};
        end
        return w;
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        term_w     = '0;
        for (int i = 0; i < 8; i++) term_w[i*19 + 18] = 1'b1;
        reset      = 1'b1;
        gen_start  = 1'b0;
        move_valid = 1'b0;
        move_data  = '0;
        move_last  = 1'b0;
        gen_end    = 1'b0;
        rden       = 1'b0;

        // Reset and idle
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_empty", 152'(fifoEmpty), 152'(1));
        chk("rst_done", 152'(done), 152'(0));
        chk("rst_ready", 152'(move_ready), 152'(0));
        chk("rst_out151", 152'(fifoOut[151]), 152'(1));
        chk("rst_out", fifoOut, term_w);
        chk("rst_count", 152'(move_count), 152'(0));

        // Three-move list, partial flush then terminator
        pulse_gen_start();
        chk("l1_ready", 152'(move_ready), 152'(1));
        send(18'h00001, 1'b0, 1'b0);
        send(18'h00002, 1'b0, 1'b0);
        send(18'h00003, 1'b1, 1'b0);
        wait_done("l1_done");
        chk("l1_count", 152'(move_count), 152'(3));
        chk("l1_nonempty", 152'(fifoEmpty), 152'(0));
        chk("l1_flag2", 152'(fifoOut[56]), 152'(0));
        chk("l1_flag3", 152'(fifoOut[75]), 152'(1));
        exp_w = term_w;
        exp_w[18:0]  = {1'b0, 18'h00001};
        exp_w[37:19] = {1'b0, 18'h00002};
        exp_w[56:38] = {1'b0, 18'h00003};
        pop_check("l1_word0", exp_w);
        pop_check("l1_term", term_w);
        chk("l1_empty", 152'(fifoEmpty), 152'(1));
        chk("l1_done_hold", 152'(done), 152'(1));

        // Exactly eight moves: full word then terminator, no empty flush word
        pulse_gen_start();
        chk("l2_clr_empty", 152'(fifoEmpty), 152'(1));
        chk("l2_clr_done", 152'(done), 152'(0));
        for (int i = 0; i < 8; i++) send(18'(16 + i), (i == 7), 1'b0);
        wait_done("l2_done");
        chk("l2_count", 152'(move_count), 152'(8));
        pop_check("l2_full", pack(16, 8));
        pop_check("l2_term", term_w);
        chk("l2_empty", 152'(fifoEmpty), 152'(1));

        // Back-pressure: 16 words buffered, 17th held until a pop frees a slot
        pulse_gen_start();
        for (int i = 1; i <= 136; i++) send(18'(i), 1'b0, 1'b0);
        #1;
        chk("bp_ready_low", 152'(move_ready), 152'(0));
        chk("bp_count136", 152'(move_count), 152'(136));
        repeat (3) tick();
        chk("bp_ready_hold", 152'(move_ready), 152'(0));
        chk("bp_head", fifoOut, pack(1, 8));
        rden = 1'b1;
        #1;
        chk("bp_ready_rden", 152'(move_ready), 152'(1));
        tick();
        rden = 1'b0;
        #1;
        chk("bp_ready_after", 152'(move_ready), 152'(1));
        chk("bp_head2", fifoOut, pack(9, 8));
        for (int i = 137; i <= 144; i++) send(18'(i), (i == 144), 1'b0);
        repeat (3) tick();
        chk("bp_stall_done", 152'(done), 152'(0));
        chk("bp_count144", 152'(move_count), 152'(144));
        for (int k = 2; k <= 18; k++) pop_check($sformatf("bp_word%0d", k), pack(1 + 8*(k-1), 8));
        wait_done("bp_done");
        pop_check("bp_term", term_w);
        chk("bp_empty", 152'(fifoEmpty), 152'(1));

        // Restart mid-list discards partial work; gen_end alone gives a bare terminator
        pulse_gen_start();
        for (int i = 0; i < 5; i++) send(18'(32 + i), 1'b0, 1'b0);
        pulse_gen_start();
        chk("rs_empty", 152'(fifoEmpty), 152'(1));
        chk("rs_count", 152'(move_count), 152'(0));
        gen_end = 1'b1;
        tick();
        gen_end = 1'b0;
        wait_done("rs_done");
        pop_check("rs_term_only", term_w);
        chk("rs_empty_end", 152'(fifoEmpty), 152'(1));

        // rden on empty is ignored; move with gen_end is treated as the last move
        pulse_gen_start();
        rden = 1'b1;
        tick();
        tick();
        rden = 1'b0;
        #1;
        chk("er_empty", 152'(fifoEmpty), 152'(1));
        chk("er_out", fifoOut, term_w);
        send(18'h3ABCD, 1'b0, 1'b1);
        wait_done("ge_done");
        exp_w = term_w;
        exp_w[18:0] = {1'b0, 18'h3ABCD};
        pop_check("ge_word", exp_w);
        pop_check("ge_term", term_w);
        chk("ge_empty", 152'(fifoEmpty), 152'(1));

        // Reset in the middle of a list
        pulse_gen_start();
        for (int i = 0; i < 3; i++) send(18'(64 + i), 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mr_empty", 152'(fifoEmpty), 152'(1));
        chk("mr_ready", 152'(move_ready), 152'(0));
        chk("mr_count", 152'(move_count), 152'(0));
        chk("mr_done", 152'(done), 152'(0));
        chk("mr_out", fifoOut, term_w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
